// File: rtl/demux18_pkg.sv
// Shared constants and helpers for the mux/demux serial link.
// The mask helper is sized generously so either side can truncate it to its own width.
package demux18_pkg;

  localparam int DESER_WIDTH = 8;
  localparam int DESER_SEL_W = 3;
  localparam int MASK_MAX_W  = 64;

  function automatic logic [MASK_MAX_W-1:0] onehot_mask(input int unsigned idx);
    return MASK_MAX_W'(1) << idx;
  endfunction

endpackage

// File: rtl/demux18_deser_out.sv
// Single-entry output holding register with valid/ready consume logic.
module deser_out_reg
  import demux18_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             consume,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             full_blocking
);

  assign full_blocking = valid && !consume;

  // A load never meets a blocking hold: the producer stalls its final bit instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      word  <= load_word;
      valid <= 1'b1;
    end else if (valid && consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux18_deser.sv
// Serial-to-parallel deserializer: collects LSB-first bits into WIDTH-bit words
// and hands them downstream through a one-word valid/ready holding register.
module demux18_deser
  import demux18_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [SEL_W-1:0] bit_idx,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int AW = WIDTH - 1;

  // The top bit never lives in acc; it goes straight into the output word.
  logic [SEL_W-1:0] cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    bit_mask;
  logic             last, acc_en, load, full_blocking;

  assign last     = (cnt == SEL_W'(WIDTH - 1));
  assign in_ready = !(last && full_blocking);
  assign acc_en   = in_valid && in_ready;
  assign load     = acc_en && !in_sof && last;
  assign bit_mask = AW'(onehot_mask(32'(cnt)));
  assign bit_idx  = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (acc_en) begin
        if (in_sof) begin
          acc       <= AW'(in_bit);
          cnt       <= SEL_W'(1);
          frame_err <= (cnt != '0);
        end else if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= in_bit ? (acc | bit_mask) : (acc & ~bit_mask);
          cnt <= cnt + SEL_W'(1);
        end
      end
    end
  end

  deser_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_word    ({in_bit, acc}),
    .consume      (out_ready),
    .word         (out_word),
    .valid        (out_valid),
    .full_blocking(full_blocking)
  );

endmodule
